// File: rtl/alu_ctrl.sv
// Serial issue controller: accept one instruction, pulse the ALU, write its result back; accept-to-writeback 3 cycles.
// Backpressure: inst_ready is low from accept until write-back or ALU timeout returns the FSM to IDLE.
module alu_ctrl #(
    parameter int DWIDTH  = 16,
    parameter int AWIDTH  = 2,
    parameter int TIMEOUT = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              inst_valid,
    output logic              inst_ready,
    input  logic [2:0]        inst_func,
    input  logic [AWIDTH-1:0] inst_rd,
    input  logic [AWIDTH-1:0] inst_rs,
    input  logic [AWIDTH-1:0] inst_rt,
    input  logic              inst_use_imm,
    input  logic [DWIDTH-1:0] inst_imm,
    output logic              alu_en,
    output logic [2:0]        alu_func,
    output logic [DWIDTH-1:0] alu_a,
    output logic [DWIDTH-1:0] alu_b,
    input  logic [DWIDTH-1:0] alu_result,
    input  logic              alu_done,
    output logic              wb_valid,
    output logic [AWIDTH-1:0] wb_addr,
    output logic [DWIDTH-1:0] wb_data,
    input  logic [AWIDTH-1:0] rd_addr,
    output logic [DWIDTH-1:0] rd_data,
    output logic              timeout_err
);

    localparam int NREG = 1 << AWIDTH;
    localparam int CW   = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_WB
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic              accept;
    logic              wb_fire;
    logic              to_fire;
    logic [DWIDTH-1:0] regs [NREG];
    logic [AWIDTH-1:0] rd_q;
    logic [CW-1:0]     cnt;

    assign inst_ready = (state == S_IDLE);
    assign accept     = inst_valid & inst_ready;
    assign rd_data    = regs[rd_addr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        wb_fire   = 1'b0;
        to_fire   = 1'b0;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    state_nxt = S_ISSUE;
                end
            end
            S_ISSUE: begin
                state_nxt = S_WAIT;
            end
            S_WAIT: begin
                // cnt counts completed WAIT cycles; this is the TIMEOUT-th one when it equals TIMEOUT-1
                if (alu_done) begin
                    wb_fire   = 1'b1;
                    state_nxt = S_WB;
                end else if (cnt == CW'(TIMEOUT - 1)) begin
                    to_fire   = 1'b1;
                    state_nxt = S_IDLE;
                end
            end
            S_WB: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_en      <= 1'b0;
            alu_func    <= '0;
            alu_a       <= '0;
            alu_b       <= '0;
            rd_q        <= '0;
            cnt         <= '0;
            wb_valid    <= 1'b0;
            wb_addr     <= '0;
            wb_data     <= '0;
            timeout_err <= 1'b0;
            for (int i = 0; i < NREG; i++) begin
                regs[i] <= '0;
            end
        end else begin
            alu_en   <= accept;
            wb_valid <= wb_fire;
            if (accept) begin
                alu_func <= inst_func;
                alu_a    <= regs[inst_rs];
                alu_b    <= inst_use_imm ? inst_imm : regs[inst_rt];
                rd_q     <= inst_rd;
            end
            if (state == S_ISSUE) begin
                cnt <= '0;
            end else if (state == S_WAIT && !alu_done) begin
                cnt <= cnt + CW'(1);
            end
            if (wb_fire) begin
                regs[rd_q] <= alu_result;
                wb_addr    <= rd_q;
                wb_data    <= alu_result;
            end
            if (to_fire) begin
                timeout_err <= 1'b1;
            end
        end
    end

endmodule

// File: doc/alu_ctrl.md
# alu_ctrl

Issue-side controller for the datapath ALU. Accepts one instruction at a time over a valid/ready port and reads source operands from an internal register file. Drives the ALU's enable, function and operand inputs for exactly one cycle, waits for the ALU's completion strobe, then writes the result back to the destination register. It sits between the instruction source and the ALU; it is the initiator for the ALU's enable/done protocol.

## Interface
- DWIDTH, 16, data width; matches the ALU.
- AWIDTH, 2, register address width; register file has 2**AWIDTH entries.
- TIMEOUT, 8, maximum WAIT cycles allowed for the ALU done strobe (≥1).

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst_n  in  1  asynchronous, active-low reset.
- inst_valid  in  1  instruction present.
- inst_ready  out  1  controller can accept an instruction.
- inst_func  in  3  ALU function code, using the `alufunc.vh` encodings; passed through unchanged.
- inst_rd / inst_rs / inst_rt  in  AWIDTH each  destination, source A and source B register.
- inst_use_imm  in  1  1: operand B = inst_imm; 0: operand B = reg[inst_rt].
- inst_imm  in  DWIDTH  immediate.
- alu_en  out  1  drives ALU en_in.
- alu_func  out  3  drives ALU function select.
- alu_a, alu_b  out  DWIDTH each  ALU operands.
- alu_result  in  DWIDTH  ALU output.
- alu_done  in  1  ALU en_out.
- wb_valid  out  1  one-cycle write-back strobe.
- wb_addr  out  AWIDTH, wb_data  out  DWIDTH  write-back destination and value.
- rd_addr  in  AWIDTH, rd_data  out  DWIDTH  combinational debug read: rd_data = reg[rd_addr].
- timeout_err  out  1  sticky error flag.

## Operation
- States: IDLE, ISSUE, WAIT, WB. Reset state is IDLE.
- Reset values:
  - All outputs 0, except inst_ready = 1 (IDLE).
  - All registers 0.
  - Timeout counter 0.
- IDLE:
  - inst_ready = 1.
  - On inst_valid & inst_ready: register alu_func = inst_func, alu_a = reg[rs], alu_b = use_imm ? imm : reg[rt], and latch rd.
  - Set alu_en = 1 and go to ISSUE.
- ISSUE: alu_en = 1 for exactly this cycle. At the next edge, clear alu_en, clear the counter, go to WAIT.
- WAIT:
  - If alu_done = 1: write reg[rd] = alu_result, wb_addr = rd, wb_data = alu_result, wb_valid = 1, go to WB.
  - Otherwise increment the counter. When TIMEOUT WAIT cycles pass without alu_done: set timeout_err, perform no write, return to IDLE.
- WB: wb_valid = 1 for this cycle only, then go to IDLE.
- alu_func, alu_a and alu_b hold their values until the next accept.
- alu_done outside WAIT is ignored.
- inst_ready = 0 in ISSUE, WAIT and WB; no instruction is accepted there.
- No hazard logic is needed; execution is strictly serial.
- Arithmetic is performed by the ALU modulo 2**DWIDTH. Undefined function codes are not checked here; whatever the ALU returns is written back.
- timeout_err is cleared only by rst_n.
- Reset mid-operation (any state): immediate return to reset values. A late alu_done after reset release is ignored.

## Timing
- Edges and cycles are numbered from the accept:
  - Cycle 0: accept.
  - Cycle 1: alu_en = 1.
  - Cycle 2: ALU asserts alu_done (one-cycle ALU latency).
  - Cycle 3: wb_valid = 1.
  - Cycle 4: inst_ready = 1.
- Accept-to-write-back latency is 3 cycles. Maximum throughput is one instruction per 4 cycles.
- rd_data reflects a write from the cycle after the write edge (cycle 3 onward).
- With inst_valid held high, consecutive accepts are exactly 4 cycles apart.
- Timeout: with alu_done never asserted, timeout_err rises after TIMEOUT WAIT cycles and inst_ready rises in the same cycle.

## Test plan
- Reset: pulse rst_n low mid-clock. Required:
  - All outputs 0 asynchronously, inst_ready = 1.
  - rd_data = 0 for addresses 0..3.
- MOVI r1 ← 0x1234 (use_imm = 1). Required:
  - alu_en high exactly 1 cycle with alu_b = 0x1234.
  - wb_valid at cycle 3 with wb_addr = 1, wb_data = 0x1234.
  - rd_data(1) = 0x1234 afterward.
- MOVI r2 ← 0x0001, then SUB r3 = r2 − r1 (r1 = 0x1234). Required:
  - alu_a = 0x0001, alu_b = 0x1234.
  - wb_data = 0xEDCD (wrap-around).
- Back-to-back: inst_valid held high with ADD then AND. Required:
  - Accepts 4 cycles apart; inst_ready low in cycles 1–3.
  - The second instruction sees the first's result.
- Timeout: bench ALU model suppresses done, TIMEOUT = 8. Required:
  - timeout_err rises 8 WAIT cycles after ISSUE.
  - No wb_valid; reg[rd] unchanged.
  - The next instruction completes normally; timeout_err stays 1 until reset.
- Reset in WAIT: assert rst_n low one cycle after ISSUE, with alu_done arriving during or after reset. Required:
  - No wb_valid; registers 0; state IDLE.
